sap1_sequencer: RTL and testbench

- Microprogram sequencer for the SAP-1 datapath: ULA, IR, MAR, AR, BR, OUT, PC, MEM and bus MUX.
- Steps a T-state ring (T1..T6) and decodes the IR opcode into the 12-bit control word that drives register loads and bus enables.
- Adds free-run / single-step gating, a latched halt state and an end-of-instruction strobe for the debug ports.

---
 rtl/sap1_pkg.sv | 66 ++++++
 rtl/sap1_ring_counter.sv | 44 ++++
 rtl/sap1_sequencer.sv | 104 ++++++++++
 tb/tb_sap1_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 sequencer shared definitions: control-word bit map, opcodes,
// T-state enum and the per-state control-word constants.
package sap1_pkg;

    localparam int CW_W = 12;

    // Control-word bit positions
    localparam int CW_EN_ALU  = 0;
    localparam int CW_ADD_SUB = 1;
    localparam int CW_L_AR    = 2;
    localparam int CW_EN_AR   = 3;
    localparam int CW_L_OUT   = 4;
    localparam int CW_L_BR    = 5;
    localparam int CW_EN_IR   = 6;
    localparam int CW_L_IR    = 7;
    localparam int CW_EN_MEM  = 8;
    localparam int CW_L_MAR   = 9;
    localparam int CW_EN_PC   = 10;
    localparam int CW_L_PC    = 11;

    // Opcodes (IR[7:4])
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    // Per-state control words
    localparam logic [CW_W-1:0] CW_NOP    = 12'h000;
    localparam logic [CW_W-1:0] CW_FETCH1 = 12'h600;
    localparam logic [CW_W-1:0] CW_FETCH2 = 12'h800;
    localparam logic [CW_W-1:0] CW_FETCH3 = 12'h180;
    localparam logic [CW_W-1:0] CW_ADDR4  = 12'h240;
    localparam logic [CW_W-1:0] CW_LDA5   = 12'h104;
    localparam logic [CW_W-1:0] CW_LDB5   = 12'h120;
    localparam logic [CW_W-1:0] CW_ADD6   = 12'h005;
    localparam logic [CW_W-1:0] CW_SUB6   = 12'h007;
    localparam logic [CW_W-1:0] CW_OUT4   = 12'h018;

    // Map the one-hot ring plus halt flag onto the state enum.
    function automatic state_t ring_state(
        input logic [5:0] ring,
        input logic       halted
    );
        state_t s;
        s = S_T1;
        if (halted)       s = S_HALT;
        else if (ring[1]) s = S_T2;
        else if (ring[2]) s = S_T3;
        else if (ring[3]) s = S_T4;
        else if (ring[4]) s = S_T5;
        else if (ring[5]) s = S_T6;
        return s;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot six-state T-state ring with advance, sync clear, early return
// to T1 and a latched halt that freezes the ring at all-zero.
//   clk        : clock
//   i_clr      : synchronous clear to T1 (active-high)
//   i_adv      : advance one T-state this clock
//   i_load_t1  : on advance, jump to T1 instead of rotating
//   i_halt     : on advance, enter halt (ring all-zero)
//   o_ring     : one-hot T-state, bit0 = T1
//   o_halted   : halt latched
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_adv,
    input  logic       i_load_t1,
    input  logic       i_halt,
    output logic [5:0] o_ring,
    output logic       o_halted
);

    logic [5:0] r_ring;
    logic       r_halted;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ring   <= 6'b000001;
            r_halted <= 1'b0;
        end else if (!r_halted && i_adv) begin
            if (i_halt) begin
                r_ring   <= 6'b000000;
                r_halted <= 1'b1;
            end else if (i_load_t1) begin
                r_ring <= 6'b000001;
            end else begin
                r_ring <= {r_ring[4:0], r_ring[5]};
            end
        end
    end

    assign o_ring   = r_ring;
    assign o_halted = r_halted;

endmodule

// File: rtl/sap1_sequencer.sv
// SAP-1 microprogram sequencer: T-state ring plus opcode decode into the
// 12-bit control word, with run/step gating, halt and end-of-instruction.
// Optional build macro SAP1_VARIABLE_MCYCLE_EN: LDA ends after T5, OUT
// and unknown opcodes end after T4; otherwise all take six T-states.
//   clk        : clock
//   mr         : synchronous active-high master reset
//   inst       : opcode IR[7:4], valid from T4
//   run        : free-run advance
//   step       : single-step advance while run=0
//   cw         : control word
//   tstate     : one-hot T-state, zero in halt
//   halted     : halt latched
//   instr_done : final T-state of an instruction on an advancing clock
module sap1_sequencer
    import sap1_pkg::*;
(
    input  logic            clk,
    input  logic            mr,
    input  logic [3:0]      inst,
    input  logic            run,
    input  logic            step,
    output logic [CW_W-1:0] cw,
    output logic [5:0]      tstate,
    output logic            halted,
    output logic            instr_done
);

    logic [5:0]      w_ring;
    logic            w_halted;
    logic            w_adv;
    logic            w_mem_op;
    logic            w_is_hlt;
    logic            w_halt_req;
    logic            w_early;
    logic            w_last;
    logic [CW_W-1:0] w_cw;
    logic [4:0]      w_en;
    state_t          w_state;

    assign w_adv    = run | step;
    assign w_state  = ring_state(w_ring, w_halted);
    assign w_mem_op = (inst == OP_LDA) || (inst == OP_ADD) ||
                      (inst == OP_SUB);
    assign w_is_hlt = (inst == OP_HLT);

    assign w_halt_req = (w_state == S_T4) && w_is_hlt;

`ifdef SAP1_VARIABLE_MCYCLE_EN
    assign w_early = ((w_state == S_T4) && !w_mem_op && !w_is_hlt) ||
                     ((w_state == S_T5) && (inst == OP_LDA));
`else
    assign w_early = 1'b0;
`endif

    // In the variable build T6 is only reached by ADD/SUB.
    assign w_last = (w_state == S_T6) || w_halt_req || w_early;

    sap1_ring_counter u_ring (
        .clk       (clk),
        .i_clr     (mr),
        .i_adv     (w_adv),
        .i_load_t1 (w_early),
        .i_halt    (w_halt_req),
        .o_ring    (w_ring),
        .o_halted  (w_halted)
    );

    always_comb begin
        w_cw = CW_NOP;
        unique case (w_state)
            S_T1: w_cw = CW_FETCH1;
            S_T2: w_cw = CW_FETCH2;
            S_T3: w_cw = CW_FETCH3;
            S_T4: begin
                if (w_mem_op)          w_cw = CW_ADDR4;
                else if (inst == OP_OUT) w_cw = CW_OUT4;
            end
            S_T5: begin
                if (inst == OP_LDA)      w_cw = CW_LDA5;
                else if (inst == OP_ADD) w_cw = CW_LDB5;
                else if (inst == OP_SUB) w_cw = CW_LDB5;
            end
            S_T6: begin
                if (inst == OP_ADD)      w_cw = CW_ADD6;
                else if (inst == OP_SUB) w_cw = CW_SUB6;
            end
            S_HALT: w_cw = CW_NOP;
        endcase
    end

    assign cw         = mr ? CW_NOP : w_cw;
    assign instr_done = !mr && w_adv && w_last;
    assign tstate     = w_ring;
    assign halted     = w_halted;

    // Only one bus driver may be enabled at a time.
    assign w_en = {cw[CW_EN_PC], cw[CW_EN_MEM], cw[CW_EN_IR],
                   cw[CW_EN_AR], cw[CW_EN_ALU]};

    always @(posedge clk) begin
        assert ($onehot0(w_en));
    end

endmodule

// File: tb/tb_sap1_sequencer.sv
// Directed table-driven bench for sap1_sequencer.
// Each row: inputs held for one clock, outputs checked before the edge.
module tb_sap1_sequencer;

    logic        clk;
    logic        mr;
    logic [3:0]  inst;
    logic        run;
    logic        step;
    logic [11:0] cw;
    logic [5:0]  tstate;
    logic        halted;
    logic        instr_done;

    int n_pass;
    int n_total;

    typedef struct {
        logic        mr;
        logic        run;
        logic        step;
        logic [3:0]  inst;
        logic [11:0] cw;
        logic [5:0]  ts;
        logic        h;
        logic        d;
        logic        chk;
    } vec_t;

    vec_t q[$];

    sap1_sequencer dut (
        .clk        (clk),
        .mr         (mr),
        .inst       (inst),
        .run        (run),
        .step       (step),
        .cw         (cw),
        .tstate     (tstate),
        .halted     (halted),
        .instr_done (instr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(
        input logic        m,
        input logic        r,
        input logic        s,
        input logic [3:0]  op,
        input logic [11:0] c,
        input logic [5:0]  t,
        input logic        h,
        input logic        d,
        input logic        k
    );
        vec_t v;
        v.mr = m; v.run = r; v.step = s; v.inst = op;
        v.cw = c; v.ts = t; v.h = h; v.d = d; v.chk = k;
        q.push_back(v);
    endtask

    // Free-running six-state instruction with given T4..T6 words.
    task automatic add_run6(
        input logic [3:0]  op,
        input logic [11:0] c4,
        input logic [11:0] c5,
        input logic [11:0] c6
    );
        add(0, 1, 0, op, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, op, 12'h800, 6'h02, 0, 0, 1);
        add(0, 1, 0, op, 12'h180, 6'h04, 0, 0, 1);
        add(0, 1, 0, op, c4,      6'h08, 0, 0, 1);
        add(0, 1, 0, op, c5,      6'h10, 0, 0, 1);
        add(0, 1, 0, op, c6,      6'h20, 0, 1, 1);
    endtask

    task automatic add_run4(input logic [3:0] op, input logic [11:0] c4);
        add(0, 1, 0, op, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, op, 12'h800, 6'h02, 0, 0, 1);
        add(0, 1, 0, op, 12'h180, 6'h04, 0, 0, 1);
        add(0, 1, 0, op, c4,      6'h08, 0, 1, 1);
    endtask

    task automatic chk1(
        input int    idx,
        input string nm,
        input logic [11:0] got,
        input logic [11:0] exp
    );
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL v%0d %s got %h want %h", idx, nm, got, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        mr   = 1'b1;
        run  = 1'b1;
        step = 1'b0;
        inst = 4'h1;

        // Reset: tstate/halted unknown until the first reset edge
        add(1, 1, 0, 4'h1, 12'h000, 6'h00, 0, 0, 0);
        add(1, 1, 0, 4'h1, 12'h000, 6'h01, 0, 0, 1);
        // ADD, SUB
        add_run6(4'h1, 12'h240, 12'h120, 12'h005);
        add_run6(4'h2, 12'h240, 12'h120, 12'h007);
`ifdef SAP1_VARIABLE_MCYCLE_EN
        add_run4(4'hE, 12'h018);
        add_run4(4'h5, 12'h000);
`else
        add_run6(4'hE, 12'h018, 12'h000, 12'h000);
        add_run6(4'h5, 12'h000, 12'h000, 12'h000);
`endif
        // Single-step LDA, step pulsed every few clocks
        add(0, 0, 0, 4'h0, 12'h600, 6'h01, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h600, 6'h01, 0, 0, 1);
        add(0, 0, 1, 4'h0, 12'h600, 6'h01, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h800, 6'h02, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h800, 6'h02, 0, 0, 1);
        add(0, 0, 1, 4'h0, 12'h800, 6'h02, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h180, 6'h04, 0, 0, 1);
        add(0, 0, 1, 4'h0, 12'h180, 6'h04, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h240, 6'h08, 0, 0, 1);
        add(0, 0, 1, 4'h0, 12'h240, 6'h08, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h104, 6'h10, 0, 0, 1);
`ifdef SAP1_VARIABLE_MCYCLE_EN
        add(0, 0, 1, 4'h0, 12'h104, 6'h10, 0, 1, 1);
`else
        add(0, 0, 1, 4'h0, 12'h104, 6'h10, 0, 0, 1);
        add(0, 0, 0, 4'h0, 12'h000, 6'h20, 0, 0, 1);
        add(0, 0, 1, 4'h0, 12'h000, 6'h20, 0, 1, 1);
`endif
        // LDA aborted by reset at T5
        add(0, 1, 0, 4'h0, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, 4'h0, 12'h800, 6'h02, 0, 0, 1);
        add(0, 1, 0, 4'h0, 12'h180, 6'h04, 0, 0, 1);
        add(0, 1, 0, 4'h0, 12'h240, 6'h08, 0, 0, 1);
        add(1, 1, 0, 4'h0, 12'h000, 6'h10, 0, 0, 1);
        // HLT
        add(0, 1, 0, 4'hF, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, 4'hF, 12'h800, 6'h02, 0, 0, 1);
        add(0, 1, 0, 4'hF, 12'h180, 6'h04, 0, 0, 1);
        add(0, 1, 0, 4'hF, 12'h000, 6'h08, 0, 1, 1);
        for (int i = 0; i < 10; i++)
            add(0, 1, 1, 4'hF, 12'h000, 6'h00, 1, 0, 1);
        add(1, 1, 1, 4'hF, 12'h000, 6'h00, 1, 0, 1);
        add(0, 0, 0, 4'h1, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, 4'h1, 12'h600, 6'h01, 0, 0, 1);
        add(0, 1, 0, 4'h1, 12'h800, 6'h02, 0, 0, 1);

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            mr   = q[i].mr;
            run  = q[i].run;
            step = q[i].step;
            inst = q[i].inst;
            #1;
            chk1(i, "cw", cw, q[i].cw);
            chk1(i, "instr_done", {11'b0, instr_done}, {11'b0, q[i].d});
            if (q[i].chk) begin
                chk1(i, "tstate", {6'b0, tstate}, {6'b0, q[i].ts});
                chk1(i, "halted", {11'b0, halted}, {11'b0, q[i].h});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
